// File: rtl/apb_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : apb_cmd_sequencer
// Purpose  : Command FIFO in front of apb_master. Issues one command at a
//            time as a single-cycle data_valid pulse, then collects the
//            completion (done/error/local timeout) into a valid/ready
//            response.
// Revision : 1.0 - initial release
// ============================================================================
module apb_cmd_sequencer #(
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                     apb_clk,
   input  logic                     apb_reset,
   // command input
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [7:0]               cmd_addr,
   input  logic [31:0]              cmd_wdata,
   input  logic                     cmd_write,
   output logic [$clog2(DEPTH):0]   cmd_count,
   // apb_master system-task interface
   output logic [7:0]               addr,
   output logic                     data_valid,
   output logic [31:0]              data,
   output logic                     data_dir,
   input  logic [31:0]              read_out_data,
   input  logic                     transaction_done,
   input  logic                     apb_tranerr,
   // response output
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [31:0]              rsp_rdata,
   output logic                     rsp_err,
   output logic                     rsp_timeout,
   output logic                     busy
);

   localparam int c_AW  = $clog2(DEPTH);
   localparam int c_CW  = c_AW + 1;
   localparam int c_WDW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam int c_EW  = 41;   // {write, addr[7:0], wdata[31:0]}

   localparam logic [c_CW-1:0]  c_FULL    = c_CW'(DEPTH);
   localparam logic [c_CW-1:0]  c_CNT_ONE = c_CW'(1);
   localparam logic [c_AW-1:0]  c_PTR_ONE = c_AW'(1);
   localparam logic [c_WDW-1:0] c_WD_ONE  = c_WDW'(1);
   localparam logic [c_WDW-1:0] c_WD_LAST = c_WDW'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [c_EW-1:0]  r_mem [DEPTH];
   logic [c_AW-1:0]  r_wptr;
   logic [c_AW-1:0]  r_rptr;
   logic [c_CW-1:0]  r_count;
   logic [1:0]       r_state;
   logic [c_WDW-1:0] r_wd;

   logic             w_push;
   logic             w_pop;
   logic [c_EW-1:0]  w_head;
   logic             w_head_write;
   logic [7:0]       w_head_addr;
   logic [31:0]      w_head_wdata;

   assign cmd_ready    = (r_count != c_FULL);
   assign cmd_count    = r_count;
   assign w_push       = cmd_valid && cmd_ready;
   // Only IDLE may pop, so at most one transfer is ever outstanding.
   assign w_pop        = (r_state == S_IDLE) && (r_count != '0);
   assign w_head       = r_mem[r_rptr];
   assign w_head_write = w_head[40];
   assign w_head_addr  = w_head[39:32];
   assign w_head_wdata = w_head[31:0];
   assign busy         = (r_state != S_IDLE) || (r_count != '0) || rsp_valid;

   // FIFO storage: written on push, no reset needed for the payload.
   always_ff @(posedge apb_clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= {cmd_write, cmd_addr, cmd_wdata};
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
   always_ff @(posedge apb_clk) begin
      if (apb_reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + c_PTR_ONE;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + c_PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Issue/complete state machine with watchdog and response register.
   always_ff @(posedge apb_clk) begin
      if (apb_reset) begin
         r_state     <= S_IDLE;
         r_wd        <= '0;
         addr        <= '0;
         data        <= '0;
         data_dir    <= 1'b0;
         data_valid  <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               data_valid <= 1'b0;
               if (w_pop) begin
                  addr       <= w_head_addr;
                  data       <= w_head_write ? w_head_wdata : 32'h0;
                  data_dir   <= w_head_write;
                  data_valid <= 1'b1;
                  r_state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               // One-cycle pulse so apb_master launches exactly once.
               data_valid <= 1'b0;
               r_wd       <= '0;
               r_state    <= S_WAIT;
            end
            S_WAIT: begin
               if (apb_tranerr) begin
                  rsp_valid   <= 1'b1;
                  rsp_err     <= 1'b1;
                  rsp_timeout <= 1'b0;
                  rsp_rdata   <= '0;
                  r_wd        <= '0;
                  r_state     <= S_RESP;
               end else if (transaction_done) begin
                  rsp_valid   <= 1'b1;
                  rsp_err     <= 1'b0;
                  rsp_timeout <= 1'b0;
                  rsp_rdata   <= data_dir ? 32'h0 : read_out_data;
                  r_wd        <= '0;
                  r_state     <= S_RESP;
               end else if (r_wd == c_WD_LAST) begin
                  rsp_valid   <= 1'b1;
                  rsp_err     <= 1'b0;
                  rsp_timeout <= 1'b1;
                  rsp_rdata   <= '0;
                  r_wd        <= '0;
                  r_state     <= S_RESP;
               end else begin
                  r_wd <= r_wd + c_WD_ONE;
               end
            end
            S_RESP: begin
               // Late completions are ignored here; response held until taken.
               if (rsp_ready) begin
                  rsp_valid   <= 1'b0;
                  rsp_err     <= 1'b0;
                  rsp_timeout <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_apb_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_cmd_sequencer
// Purpose  : Self-checking bench for apb_cmd_sequencer: vector table plus
//            hand-written corner sequences, scoreboard queues for issued
//            commands and responses, and a small apb_master responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_cmd_sequencer;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 64;
   localparam int K_DONE  = 0;   // transaction_done after dly cycles
   localparam int K_ERR   = 1;   // apb_tranerr + transaction_done together
   localparam int K_NONE  = 2;   // never completes
   localparam int K_LATE  = 3;   // completes well after the watchdog fires
   localparam logic [31:0] JUNK = 32'h1357_2468;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic        write;
      int          kind;
      int          dly;
      logic [31:0] rdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic        exp_to;
   } vec_t;

   typedef struct { logic [7:0] addr; logic [31:0] data; logic dir; } issue_t;
   typedef struct { logic [31:0] rdata; logic err; logic to; } rsp_t;
   typedef struct { int kind; int dly; logic [31:0] rdata; } beh_t;

   logic                     apb_clk;
   logic                     apb_reset;
   logic                     cmd_valid;
   logic                     cmd_ready;
   logic [7:0]               cmd_addr;
   logic [31:0]              cmd_wdata;
   logic                     cmd_write;
   logic [$clog2(DEPTH):0]   cmd_count;
   logic [7:0]               addr;
   logic                     data_valid;
   logic [31:0]              data;
   logic                     data_dir;
   logic [31:0]              read_out_data;
   logic                     transaction_done;
   logic                     apb_tranerr;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [31:0]              rsp_rdata;
   logic                     rsp_err;
   logic                     rsp_timeout;
   logic                     busy;

   issue_t exp_issue[$];
   rsp_t   exp_rsp[$];
   beh_t   beh_q[$];
   int     n_checks = 0;
   int     n_fail   = 0;

   apb_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .apb_clk(apb_clk), .apb_reset(apb_reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .cmd_write(cmd_write), .cmd_count(cmd_count),
      .addr(addr), .data_valid(data_valid), .data(data), .data_dir(data_dir),
      .read_out_data(read_out_data), .transaction_done(transaction_done),
      .apb_tranerr(apb_tranerr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .busy(busy)
   );

   initial begin
      apb_clk = 1'b0;
      forever #5 apb_clk = ~apb_clk;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge apb_clk);
      #1;
   endtask

   // Queue expectations, then offer the command until it is accepted.
   task automatic push_cmd(input vec_t v);
      issue_t ie;
      rsp_t   re;
      beh_t   be;
      int     n;
      ie.addr  = v.addr;
      ie.data  = v.write ? v.wdata : 32'h0;
      ie.dir   = v.write;
      exp_issue.push_back(ie);
      if (v.kind != K_NONE) begin
         re.rdata = v.exp_rdata;
         re.err   = v.exp_err;
         re.to    = v.exp_to;
         exp_rsp.push_back(re);
      end
      be.kind  = v.kind;
      be.dly   = v.dly;
      be.rdata = v.rdata;
      beh_q.push_back(be);
      cmd_addr  = v.addr;
      cmd_wdata = v.wdata;
      cmd_write = v.write;
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 300) begin
         tick();
         n++;
      end
      if (!cmd_ready) check("push_accept", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      cmd_wdata = $urandom;
      cmd_addr  = 8'($urandom);
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while ((exp_rsp.size() != 0 || busy) && n < budget) begin
         tick();
         n++;
      end
      check("drain_busy", busy, 0);
      check("drain_rsp_left", exp_rsp.size(), 0);
   endtask

   // Issue monitor: every data_valid must be a single-cycle pulse matching the queue head.
   initial begin
      logic   prev_dv;
      issue_t ie;
      prev_dv = 1'b0;
      forever begin
         @(negedge apb_clk);
         if (!apb_reset && data_valid === 1'b1) begin
            if (prev_dv) check("dv_single_pulse", 1, 0);
            if (exp_issue.size() == 0) begin
               check("issue_unexpected", data_valid, 0);
            end else begin
               ie = exp_issue.pop_front();
               check("issue_addr", addr, ie.addr);
               check("issue_data", data, ie.data);
               check("issue_dir", data_dir, ie.dir);
            end
         end
         prev_dv = (data_valid === 1'b1);
      end
   end

   // Response monitor: compare each handshaken response with the queue head.
   initial begin
      rsp_t re;
      forever begin
         @(negedge apb_clk);
         if (!apb_reset && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (exp_rsp.size() == 0) begin
               check("rsp_unexpected", rsp_valid, 0);
            end else begin
               re = exp_rsp.pop_front();
               check("rsp_rdata", rsp_rdata, re.rdata);
               check("rsp_err", rsp_err, re.err);
               check("rsp_timeout", rsp_timeout, re.to);
            end
         end
      end
   end

   // apb_master stand-in: completes each issued transfer per its behaviour record.
   initial begin
      beh_t b;
      transaction_done = 1'b0;
      apb_tranerr      = 1'b0;
      read_out_data    = JUNK;
      forever begin
         @(negedge apb_clk);
         if (!apb_reset && data_valid === 1'b1 && beh_q.size() != 0) begin
            b = beh_q.pop_front();
            if (b.kind != K_NONE) begin
               repeat ((b.kind == K_LATE) ? TIMEOUT + 8 : b.dly) @(posedge apb_clk);
               #1;
               transaction_done = 1'b1;
               apb_tranerr      = (b.kind == K_ERR);
               read_out_data    = b.rdata;
               @(posedge apb_clk);
               #1;
               transaction_done = 1'b0;
               apb_tranerr      = 1'b0;
               read_out_data    = JUNK;
            end
         end
      end
   end

   initial begin
      vec_t vecs[6];
      vec_t v;
      int   exp_cnt[6];
      int   n;
      int   m;

      vecs[0] = '{8'h05, 32'hDEADBEEF, 1'b1, K_DONE, 2, 32'h0,        32'h0,        1'b0, 1'b0};
      vecs[1] = '{8'h05, 32'h77777777, 1'b0, K_DONE, 3, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
      vecs[2] = '{8'h3A, 32'h12345678, 1'b1, K_ERR,  1, 32'h0,        32'h0,        1'b1, 1'b0};
      vecs[3] = '{8'h3A, 32'h0,        1'b0, K_ERR,  2, 32'h55AA55AA, 32'h0,        1'b1, 1'b0};
      vecs[4] = '{8'hC0, 32'h0F0F0F0F, 1'b1, K_DONE, 1, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0};
      vecs[5] = '{8'hFF, 32'hFFFFFFFF, 1'b0, K_DONE, 1, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
      exp_cnt = '{1, 1, 2, 3, 4, 4};

      apb_reset = 1'b1;
      cmd_valid = 1'b0;
      cmd_addr  = 8'h0;
      cmd_wdata = 32'h0;
      cmd_write = 1'b0;
      rsp_ready = 1'b1;
      repeat (3) tick();
      apb_reset = 1'b0;

      // Reset state
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_cmd_count", cmd_count, 0);
      check("rst_data_valid", data_valid, 0);
      check("rst_addr", addr, 0);
      check("rst_data", data, 0);
      check("rst_data_dir", data_dir, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_rsp_timeout", rsp_timeout, 0);
      check("rst_busy", busy, 0);

      // Table of single commands; first one also checks issue latency.
      for (int i = 0; i < 6; i++) begin
         push_cmd(vecs[i]);
         if (i == 0) begin
            check("lat_dv_t", data_valid, 0);
            check("lat_count_t", cmd_count, 1);
            tick();
            check("lat_dv_t1", data_valid, 1);
            check("lat_count_t1", cmd_count, 0);
            tick();
            check("lat_dv_t2", data_valid, 0);
            check("lat_busy", busy, 1);
         end
         wait_drain(200);
      end

      // Read-back with consumer stalled: response must hold steady.
      rsp_ready = 1'b0;
      v = '{8'h05, 32'h0, 1'b0, K_DONE, 3, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
      push_cmd(v);
      n = 0;
      while (!rsp_valid && n < 50) begin
         tick();
         n++;
      end
      for (int k = 0; k < 5; k++) begin
         check("hold_valid", rsp_valid, 1);
         check("hold_rdata", rsp_rdata, 32'hDEADBEEF);
         check("hold_err", rsp_err, 0);
         tick();
      end
      rsp_ready = 1'b1;
      wait_drain(50);

      // FIFO full / wrap / simultaneous push+pop with first completion stalled.
      for (int i = 0; i < 6; i++) begin
         v.addr      = 8'h10 + 8'(i);
         v.wdata     = 32'hA000_0000 + 32'(i);
         v.write     = (i % 2 == 0);
         v.kind      = K_DONE;
         v.dly       = (i == 0) ? 15 : 1;
         v.rdata     = 32'h1111_0000 + 32'(i);
         v.exp_rdata = v.write ? 32'h0 : v.rdata;
         v.exp_err   = 1'b0;
         v.exp_to    = 1'b0;
         push_cmd(v);
         check("full_count", cmd_count, exp_cnt[i]);
         if (i == 4) check("full_ready", cmd_ready, 0);
      end
      wait_drain(600);

      // Watchdog timeout followed by an ignored late completion.
      v = '{8'h44, 32'h0, 1'b0, K_LATE, 0, 32'h99999999, 32'h0, 1'b0, 1'b1};
      push_cmd(v);
      n = 0;
      while (!data_valid && n < 10) begin
         tick();
         n++;
      end
      m = 0;
      while (!rsp_valid && m < 200) begin
         tick();
         m++;
      end
      check("timeout_latency", m, TIMEOUT + 1);
      wait_drain(20);
      repeat (20) tick();
      check("late_rsp_valid", rsp_valid, 0);
      check("late_busy", busy, 0);

      // Reset while a transfer is in WAIT with three commands queued.
      v = '{8'h60, 32'h0, 1'b0, K_NONE, 0, 32'h0, 32'h0, 1'b0, 1'b0};
      push_cmd(v);
      for (int i = 0; i < 3; i++) begin
         v = '{8'h61 + 8'(i), 32'hB0 + 32'(i), 1'b1, K_DONE, 1, 32'h0, 32'h0, 1'b0, 1'b0};
         push_cmd(v);
      end
      repeat (3) tick();
      check("prerst_count", cmd_count, 3);
      check("prerst_busy", busy, 1);
      apb_reset = 1'b1;
      tick();
      apb_reset = 1'b0;
      check("midrst_count", cmd_count, 0);
      check("midrst_dv", data_valid, 0);
      check("midrst_rsp_valid", rsp_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_ready", cmd_ready, 1);
      exp_issue.delete();
      exp_rsp.delete();
      beh_q.delete();
      repeat (5) tick();

      // Recovery after reset.
      v = '{8'h22, 32'h0BADF00D, 1'b1, K_DONE, 2, 32'h0, 32'h0, 1'b0, 1'b0};
      push_cmd(v);
      wait_drain(100);
      check("final_issue_left", exp_issue.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
